// File: rtl/scan_capture.sv
// Receive-side monitor for the 8-digit multiplexed scan display: synchronizes SEG/AN,
// waits for a settled pattern, decodes the lit digit and rebuilds the full frame.
module scan_capture #(
    parameter int STABLE_CYCLES = 4,
    parameter int TIMEOUT       = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  SEG_in,
    input  logic [7:0]  AN_in,
    output logic [31:0] digits,
    output logic [7:0]  dp,
    output logic [7:0]  seen,
    output logic        frame_done,
    output logic        err_an,
    output logic        err_seg,
    output logic        stale
);

    localparam int CNT_W = (STABLE_CYCLES < 2) ? 1 : $clog2(STABLE_CYCLES + 1);
    localparam int TO_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_EVAL = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

    // Returns {valid, index}: valid when exactly one select line is low.
    function automatic logic [3:0] one_cold(input logic [7:0] an);
        logic [7:0] inv;
        logic [3:0] r;
        inv = ~an;
        r   = 4'b0000;
        if (inv != 8'h00 && (inv & (inv - 8'h01)) == 8'h00) begin
            r[3] = 1'b1;
            for (int i = 0; i < 8; i++) begin
                if (inv[i]) r[2:0] = 3'(i);
            end
        end
        return r;
    endfunction

    // Active-high segment pattern {a..g} to {valid, hex code}.
    function automatic logic [4:0] glyph(input logic [6:0] on);
        logic [4:0] r;
        case (on)
            7'h7E:   r = 5'h10;
            7'h30:   r = 5'h11;
            7'h6D:   r = 5'h12;
            7'h79:   r = 5'h13;
            7'h33:   r = 5'h14;
            7'h5B:   r = 5'h15;
            7'h5F:   r = 5'h16;
            7'h70:   r = 5'h17;
            7'h7F:   r = 5'h18;
            7'h7B:   r = 5'h19;
            7'h77:   r = 5'h1A;
            7'h1F:   r = 5'h1B;
            7'h4E:   r = 5'h1C;
            7'h3D:   r = 5'h1D;
            7'h4F:   r = 5'h1E;
            7'h47:   r = 5'h1F;
            default: r = 5'h00;
        endcase
        return r;
    endfunction

    logic [7:0]       an_m_q, an_s_q, seg_m_q, seg_s_q;
    logic [15:0]      key_prev_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    state_t           state_q, state_d;
    logic [31:0]      digits_q, digits_d;
    logic [7:0]       dp_q, dp_d, seen_q, seen_d;
    logic             fd_q, fd_d, ea_q, ea_d, es_q, es_d;
    logic [TO_W-1:0]  tcnt_q, tcnt_d;

    logic [15:0] key;
    logic        key_chg, blank, capture;
    logic [3:0]  oc;
    logic [4:0]  gl;
    logic [7:0]  seen_set;

    always_comb begin
        key      = {an_s_q, seg_s_q};
        key_chg  = (key != key_prev_q);
        blank    = (an_s_q == 8'hFF);
        oc       = one_cold(an_s_q);
        gl       = glyph(~seg_s_q[7:1]);
        cnt_d    = key_chg ? '0 : ((cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1));
        state_d  = state_q;
        digits_d = digits_q;
        dp_d     = dp_q;
        seen_d   = seen_q;
        seen_set = seen_q;
        fd_d     = 1'b0;
        ea_d     = 1'b0;
        es_d     = 1'b0;
        capture  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!blank) state_d = SETTLE;
            end
            SETTLE: begin
                if (key_chg) begin
                    if (blank) state_d = IDLE;
                end else if (cnt_q == CNT_EVAL) begin
                    state_d = HOLD;
                    // An AN fault takes precedence over a glyph fault.
                    if (!oc[3])      ea_d = 1'b1;
                    else if (!gl[4]) es_d = 1'b1;
                    else             capture = 1'b1;
                end
            end
            HOLD: begin
                if (key_chg) state_d = blank ? IDLE : SETTLE;
            end
            default: state_d = IDLE;
        endcase
        if (capture) begin
            digits_d[4*oc[2:0] +: 4] = gl[3:0];
            dp_d[oc[2:0]]            = ~seg_s_q[0];
            seen_set                 = seen_q | (8'b1 << oc[2:0]);
            if (seen_set == 8'hFF) begin
                fd_d   = 1'b1;
                seen_d = 8'h00;
            end else begin
                seen_d = seen_set;
            end
        end
        tcnt_d = capture ? '0 : ((tcnt_q == TO_MAX) ? tcnt_q : tcnt_q + TO_W'(1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an_m_q     <= 8'hFF;
            an_s_q     <= 8'hFF;
            seg_m_q    <= 8'hFF;
            seg_s_q    <= 8'hFF;
            key_prev_q <= 16'hFFFF;
            cnt_q      <= '0;
            state_q    <= IDLE;
            digits_q   <= 32'h0;
            dp_q       <= 8'h00;
            seen_q     <= 8'h00;
            fd_q       <= 1'b0;
            ea_q       <= 1'b0;
            es_q       <= 1'b0;
            tcnt_q     <= '0;
        end else begin
            an_m_q     <= AN_in;
            an_s_q     <= an_m_q;
            seg_m_q    <= SEG_in;
            seg_s_q    <= seg_m_q;
            key_prev_q <= key;
            cnt_q      <= cnt_d;
            state_q    <= state_d;
            digits_q   <= digits_d;
            dp_q       <= dp_d;
            seen_q     <= seen_d;
            fd_q       <= fd_d;
            ea_q       <= ea_d;
            es_q       <= es_d;
            tcnt_q     <= tcnt_d;
        end
    end

    assign digits     = digits_q;
    assign dp         = dp_q;
    assign seen       = seen_q;
    assign frame_done = fd_q;
    assign err_an     = ea_q;
    assign err_seg    = es_q;
    assign stale      = (tcnt_q == TO_MAX);

endmodule

// File: tb/tb_scan_capture.sv
// Directed bench for scan_capture: capture latency, frame assembly, error pulses,
// settling filter, stale timeout and mid-frame reset.
module tb_scan_capture;

    localparam int SC = 4;
    localparam int TO = 20;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  SEG_in, AN_in;
    logic [31:0] digits;
    logic [7:0]  dp, seen;
    logic        frame_done, err_an, err_seg, stale;

    int checks = 0;
    int errors = 0;
    int n_fd = 0, n_ea = 0, n_es = 0;
    int fd_snap;

    // SEG patterns for codes 1..8; the code-3 entry has its decimal point lit.
    logic [7:0] seg_tab [8] = '{8'h9F, 8'h25, 8'h0C, 8'h99, 8'h49, 8'h41, 8'h1F, 8'h01};

    scan_capture #(.STABLE_CYCLES(SC), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .SEG_in(SEG_in), .AN_in(AN_in),
        .digits(digits), .dp(dp), .seen(seen), .frame_done(frame_done),
        .err_an(err_an), .err_seg(err_seg), .stale(stale)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done) n_fd <= n_fd + 1;
        if (err_an)     n_ea <= n_ea + 1;
        if (err_seg)    n_es <= n_es + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [7:0] an, input logic [7:0] seg, input int n);
        AN_in  = an;
        SEG_in = seg;
        tick(n);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_digits"}, digits, 32'h0);
        check({tag, "_dp"}, {24'h0, dp}, 32'h0);
        check({tag, "_seen"}, {24'h0, seen}, 32'h0);
        check({tag, "_pulses"}, {29'h0, frame_done, err_an, err_seg}, 32'h0);
        check({tag, "_stale"}, {31'h0, stale}, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; AN_in = 8'hFF; SEG_in = 8'hFF;
        #2 rst = 1'b1;
        #1 check_zero("reset");
        tick(1);
        rst = 1'b0;

        // T1: digit 0 showing '0'; capture lands on the 7th edge after apply.
        put(8'hFE, 8'h03, 6);
        check("t1_early_seen", {24'h0, seen}, 32'h00);
        tick(1);
        check("t1_seen", {24'h0, seen}, 32'h01);
        check("t1_digits", digits, 32'h0);
        check("t1_dp", {24'h0, dp}, 32'h0);
        tick(3);
        check("t1_errs", n_ea + n_es, 0);

        // T2: full scan with codes 1..8.
        for (int d = 0; d < 8; d++) begin
            put(~(8'b1 << d), seg_tab[d], 8);
            if (d == 6) begin
                check("t2_fd_before_last", n_fd, 0);
                check("t2_seen_7", {24'h0, seen}, 32'h7F);
            end
        end
        check("t2_digits", digits, 32'h87654321);
        check("t2_seen", {24'h0, seen}, 32'h00);
        check("t2_fd", n_fd, 1);
        check("t2_dp", {24'h0, dp}, 32'h04);

        // T3: bad AN, unknown glyph, both bad.
        put(8'hFC, 8'h01, 16);
        check("t3_err_an", n_ea, 1);
        check("t3_digits_a", digits, 32'h87654321);
        check("t3_seen", {24'h0, seen}, 32'h00);
        put(8'hFB, 8'hFF, 8);
        check("t3_err_seg", n_es, 1);
        check("t3_dp", {24'h0, dp}, 32'h04);
        check("t3_digits_b", digits, 32'h87654321);
        put(8'hF0, 8'hFF, 8);
        check("t3_both_an", n_ea, 2);
        check("t3_both_seg", n_es, 1);

        // T4: SEG toggling every 2 cycles never settles; then 'A' on digit 7.
        for (int j = 0; j < 8; j++) put(8'hBF, j[0] ? 8'h25 : 8'h9F, 2);
        check("t4_toggle_seen", {24'h0, seen}, 32'h00);
        check("t4_toggle_digits", digits, 32'h87654321);
        put(8'h7F, 8'h11, 8);
        check("t4_digits", digits, 32'hA7654321);
        check("t4_dp", {24'h0, dp}, 32'h04);
        check("t4_seen", {24'h0, seen}, 32'h80);

        // T5: stale timeout.
        AN_in = 8'hFF; SEG_in = 8'hFF;
        rst = 1'b1;
        #1 check_zero("t5_rst");
        tick(1);
        rst = 1'b0;
        tick(19);
        check("t5_stale_19", {31'h0, stale}, 32'h0);
        tick(1);
        check("t5_stale_20", {31'h0, stale}, 32'h1);
        tick(5);
        check("t5_stale_25", {31'h0, stale}, 32'h1);
        put(8'hFE, 8'h9F, 6);
        check("t5_stale_pre", {31'h0, stale}, 32'h1);
        tick(1);
        check("t5_stale_clr", {31'h0, stale}, 32'h0);
        check("t5_digits", digits, 32'h00000001);
        check("t5_seen", {24'h0, seen}, 32'h01);

        // T6: reset after 3 captures discards the partial frame.
        for (int d = 0; d < 3; d++) put(~(8'b1 << d), seg_tab[d], 8);
        check("t6_seen_3", {24'h0, seen}, 32'h07);
        rst = 1'b1;
        AN_in = 8'hFF; SEG_in = 8'hFF;
        #1 check_zero("t6_rst");
        tick(1);
        rst = 1'b0;
        fd_snap = n_fd;
        for (int d = 0; d < 8; d++) begin
            put(~(8'b1 << d), seg_tab[d], 8);
            if (d == 6) check("t6_fd_before_last", n_fd, fd_snap);
        end
        check("t6_fd", n_fd, fd_snap + 1);
        check("t6_seen", {24'h0, seen}, 32'h00);
        check("t6_digits", digits, 32'h87654321);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
